register_file_2r1w: RTL and testbench
=====================================

// Module: register_file_2r1w
// PURPOSE
//  Parametrised 2-read/1-write register file; next-generation replacement for the
//  8-bit single-port register bank in the microprocessor datapath. Feeds both ALU
//  operands per cycle. Adds registered dual reads, write-to-read bypass, synchronous
//  reset with a hardware clear sweep, and a ready/valid indication to the control unit.
// PARAMETERS
//  WIDTH  8  data width of each register, in bits
//  DEPTH  4  number of registers; must be a power of 2 and >= 2
//  AW     $clog2(DEPTH)  address width (derived; do not override)
// PORTS
//  clk      in   1      clock; all state updates on posedge
//  rst      in   1      synchronous reset, active-high
//  we       in   1      write enable (honoured only while ready=1)
//  w_add    in   AW     write address
//  ip       in   WIDTH  write data
//  re       in   1      read enable (honoured only while ready=1)
//  r_add_a  in   AW     read address, port A
//  r_add_b  in   AW     read address, port B
//  op_a     out  WIDTH  registered read data, port A
//  op_b     out  WIDTH  registered read data, port B
//  op_valid out  1      1-cycle pulse: op_a/op_b updated this cycle
//  ready    out  1      1 = clear sweep done, accepting we/re
// BEHAVIOUR
//  - One clock; reset synchronous, active-high. Clock port is clk, reset port is rst.
//  - Reset (rst=1 at posedge): op_a=0, op_b=0, op_valid=0, ready=0; FSM->CLEAR, ptr=0.
//    Reset dominates every other input. Reset mid-sweep or mid-run restarts the sweep.
//  - FSM: CLEAR -> RUN.
//    CLEAR: each cycle with rst=0 writes 0 to reg[ptr], ptr++. we/re ignored,
//    op_valid=0. After reg[DEPTH-1] is written, FSM->RUN and ready=1.
//    ready therefore rises at the DEPTH-th posedge after rst is sampled low.
//  - RUN: ready=1 and stays 1 until the next rst.
//  - Write: we=1 at posedge -> reg[w_add]<=ip.
//  - Read: re=1 at posedge -> op_a<=reg[r_add_a] and op_b<=reg[r_add_b];
//    op_valid=1 for that one cycle. Latency is 1 cycle from re to data.
//    With re=0, op_a/op_b hold their values and op_valid=0.
//  - Bypass: same-cycle we=1 and re=1 with w_add==r_add_x -> op_x<=ip (write-first).
//    Both ports may bypass simultaneously.
//  - r_add_a==r_add_b is legal; both ports return the same data.
//  - No illegal addresses exist (DEPTH is a power of 2); addresses wrap naturally.
// CONFIGURATION
//  REGFILE_ZERO_REG_EN defined:
//    - reg[0] is hardwired to 0.
//    - Writes to address 0 are discarded, and bypass to address 0 is suppressed
//      (a read of address 0 always returns 0).
//    - The clear sweep still takes DEPTH cycles.
//  REGFILE_ZERO_REG_EN undefined: reg[0] is an ordinary register.
// TESTING (WIDTH=8, DEPTH=4)
//  1. rst=1 for 2 cycles, then 0 -> ready=0 for cycles 1-3, ready=1 at cycle 4;
//     then re with a=0,b=3 -> op_a=00, op_b=00, op_valid pulses once.
//  2. we with w_add=2, ip=A5; next cycle re with a=2,b=2 -> next cycle op_a=op_b=A5,
//     op_valid=1 for 1 cycle, then op_valid=0 with data held.
//  3. Same cycle: we with w_add=1, ip=3C and re with a=1,b=2 (r2=A5) ->
//     op_a=3C (bypass), op_b=A5.
//  4. we=1/re=1 driven throughout the clear sweep -> op_valid stays 0; after ready,
//     reading all 4 registers returns 00.
//  5. While ready=1 with op_a=3C, assert rst for 1 cycle -> next edge op_a=0, ready=0;
//     ready returns 4 cycles after rst falls and all registers read 00.
//  6. we with w_add=0, ip=FF, then re with a=0 -> op_a=00 with REGFILE_ZERO_REG_EN;
//     op_a=FF without it. Same-cycle write/read of address 0 gives the same results.

Source files
------------

// File: rtl/register_file_2r1w.sv
// 2-read/1-write register file with registered reads, write-first bypass and a
// post-reset clear sweep. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module register_file_2r1w #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    w_add,
   input  logic [WIDTH-1:0] ip,
   input  logic             re,
   input  logic [AW-1:0]    r_add_a,
   input  logic [AW-1:0]    r_add_b,
   output logic [WIDTH-1:0] op_a,
   output logic [WIDTH-1:0] op_b,
   output logic             op_valid,
   output logic             ready
);

`ifdef REGFILE_ZERO_REG_EN
   localparam bit LP_ZERO_REG = 1'b1;
`else
   localparam bit LP_ZERO_REG = 1'b0;
`endif

   typedef enum logic {S_CLEAR = 1'b0, S_RUN = 1'b1} state_t;

   state_t           r_state;
   logic [AW-1:0]    r_ptr;
   logic [WIDTH-1:0] r_op_a;
   logic [WIDTH-1:0] r_op_b;
   logic             r_op_valid;
   logic             r_ready;
   logic [WIDTH-1:0] r_mem [DEPTH];

   logic             w_clear;
   logic             w_wr_ok;
   logic             w_mem_we;
   logic [AW-1:0]    w_mem_addr;
   logic [WIDTH-1:0] w_mem_data;
   logic [AW-1:0]    w_rd_addr [2];
   logic [WIDTH-1:0] w_rd_data [2];

   assign w_clear    = (r_state == S_CLEAR);
   assign w_wr_ok    = !(LP_ZERO_REG && (w_add == '0));
   // The sweep and normal writes share the single memory write port.
   assign w_mem_we   = !rst && (w_clear || (we && w_wr_ok));
   assign w_mem_addr = w_clear ? r_ptr : w_add;
   assign w_mem_data = w_clear ? '0 : ip;

   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_data;
      end
   end

   assign w_rd_addr[0] = r_add_a;
   assign w_rd_addr[1] = r_add_b;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_rd
         logic w_hit;
         assign w_hit = we && re && w_wr_ok && (w_add == w_rd_addr[gi]);
         assign w_rd_data[gi] = (LP_ZERO_REG && (w_rd_addr[gi] == '0)) ? '0 :
                                w_hit ? ip : r_mem[w_rd_addr[gi]];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_CLEAR;
         r_ptr      <= '0;
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_op_valid <= 1'b0;
         r_ready    <= 1'b0;
      end else begin
         r_op_valid <= 1'b0;
         case (r_state)
            S_CLEAR: begin
               r_ptr <= r_ptr + AW'(1);
               if (r_ptr == AW'(DEPTH - 1)) begin
                  r_state <= S_RUN;
                  r_ready <= 1'b1;
               end
            end
            S_RUN: begin
               if (re) begin
                  r_op_a     <= w_rd_data[0];
                  r_op_b     <= w_rd_data[1];
                  r_op_valid <= 1'b1;
               end
            end
            default: r_state <= S_CLEAR;
         endcase
      end
   end

   assign op_a     = r_op_a;
   assign op_b     = r_op_b;
   assign op_valid = r_op_valid;
   assign ready    = r_ready;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w (WIDTH=8, DEPTH=4); expectations follow
// REGFILE_ZERO_REG_EN when it is defined.
module tb_register_file_2r1w;

   logic       clk = 1'b0;
   logic       rst;
   logic       we;
   logic [1:0] w_add;
   logic [7:0] ip;
   logic       re;
   logic [1:0] r_add_a;
   logic [1:0] r_add_b;
   logic [7:0] op_a;
   logic [7:0] op_b;
   logic       op_valid;
   logic       ready;

   int errors = 0;
   int checks = 0;

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZR = 1'b1;
`else
   localparam bit ZR = 1'b0;
`endif

   register_file_2r1w #(.WIDTH(8), .DEPTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .w_add    (w_add),
      .ip       (ip),
      .re       (re),
      .r_add_a  (r_add_a),
      .r_add_b  (r_add_b),
      .op_a     (op_a),
      .op_b     (op_b),
      .op_valid (op_valid),
      .ready    (ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_out(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic v, input logic rdy);
      chk({tag, ".op_a"}, op_a, a);
      chk({tag, ".op_b"}, op_b, b);
      chk({tag, ".valid"}, {7'd0, op_valid}, {7'd0, v});
      chk({tag, ".ready"}, {7'd0, ready}, {7'd0, rdy});
   endtask

   initial begin
      rst = 1'b1; we = 1'b0; w_add = 2'd0; ip = 8'h00;
      re = 1'b0; r_add_a = 2'd0; r_add_b = 2'd0;

      // 1. reset, sweep timing, first read
      tick();
      chk_out("rst1", 8'h00, 8'h00, 1'b0, 1'b0);
      tick();
      rst = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("sweep%0d.ready", i), {7'd0, ready}, {7'd0, (i == 4)});
      end
      re = 1'b1; r_add_a = 2'd0; r_add_b = 2'd3;
      tick();
      re = 1'b0;
      chk_out("rd03", 8'h00, 8'h00, 1'b1, 1'b1);
      tick();
      chk("rd03.pulse", {7'd0, op_valid}, 8'h00);

      // 2. write then read the same address on both ports
      we = 1'b1; w_add = 2'd2; ip = 8'hA5;
      tick();
      we = 1'b0; re = 1'b1; r_add_a = 2'd2; r_add_b = 2'd2;
      tick();
      re = 1'b0;
      chk_out("rd22", 8'hA5, 8'hA5, 1'b1, 1'b1);
      tick();
      chk_out("hold22", 8'hA5, 8'hA5, 1'b0, 1'b1);

      // 3. bypass on A, B, then both
      we = 1'b1; w_add = 2'd1; ip = 8'h3C; re = 1'b1; r_add_a = 2'd1; r_add_b = 2'd2;
      tick();
      chk_out("bypA", 8'h3C, 8'hA5, 1'b1, 1'b1);
      w_add = 2'd3; ip = 8'h5A; r_add_a = 2'd2; r_add_b = 2'd3;
      tick();
      chk_out("bypB", 8'hA5, 8'h5A, 1'b1, 1'b1);
      ip = 8'h77; r_add_a = 2'd3; r_add_b = 2'd3;
      tick();
      we = 1'b0;
      chk_out("bypAB", 8'h77, 8'h77, 1'b1, 1'b1);
      r_add_a = 2'd1; r_add_b = 2'd3;
      tick();
      re = 1'b0;
      chk_out("rd13", 8'h3C, 8'h77, 1'b1, 1'b1);

      // 5 + 4. mid-run reset with we/re held high through the sweep
      rst = 1'b1; we = 1'b1; w_add = 2'd1; ip = 8'hEE; re = 1'b1; r_add_a = 2'd1; r_add_b = 2'd2;
      tick();
      rst = 1'b0;
      chk_out("rst2", 8'h00, 8'h00, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk($sformatf("sw2_%0d.valid", i), {7'd0, op_valid}, 8'h00);
         chk($sformatf("sw2_%0d.ready", i), {7'd0, ready}, {7'd0, (i == 4)});
      end
      we = 1'b0; r_add_a = 2'd0; r_add_b = 2'd1;
      tick();
      chk_out("clr01", 8'h00, 8'h00, 1'b1, 1'b1);
      r_add_a = 2'd2; r_add_b = 2'd3;
      tick();
      re = 1'b0;
      chk_out("clr23", 8'h00, 8'h00, 1'b1, 1'b1);

      // 6. address 0 behaviour
      we = 1'b1; w_add = 2'd0; ip = 8'hFF;
      tick();
      we = 1'b0; re = 1'b1; r_add_a = 2'd0; r_add_b = 2'd2;
      tick();
      chk_out("rd0", ZR ? 8'h00 : 8'hFF, 8'h00, 1'b1, 1'b1);
      we = 1'b1; w_add = 2'd0; ip = 8'hC3; r_add_a = 2'd0; r_add_b = 2'd0;
      tick();
      we = 1'b0;
      chk_out("byp0", ZR ? 8'h00 : 8'hC3, ZR ? 8'h00 : 8'hC3, 1'b1, 1'b1);
      r_add_a = 2'd2; r_add_b = 2'd0;
      tick();
      re = 1'b0;
      chk_out("rd20", 8'h00, ZR ? 8'h00 : 8'hC3, 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
